csr_access_unit: RTL and testbench
==================================

// Module: csr_access_unit
// PURPOSE
//  Initiator side of the CSR register-file port: sequences every access the core makes to the CSR file.
//  Executes Zicsr instructions (CSRRW/S/C, CSRRWI/SI/CI) as a read-modify-write access.
//  Executes trap entry and MRET as multi-cycle sequences over the single read and single write CSR port.
//  Sits between the execute stage (valid/ready request, done response) and the CSR file.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  redirect_pc value after reset (no redirect is issued at reset)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous reset, active-high
//  req_valid    in   1   request present
//  req_ready    out  1   unit idle and accepting; transfer = req_valid & req_ready
//  req_kind     in   2   00 CSR instr, 01 trap entry, 10 MRET, 11 reserved
//  csr_op       in   3   funct3 of CSR instruction
//  csr_addr     in   12  CSR number
//  operand      in   32  rs1 value, or zimm zero-extended (I forms)
//  src_zero     in   1   rs1/zimm field == 0 (suppresses write for S/C forms)
//  trap_pc      in   32  PC of trapping instruction
//  trap_cause   in   32  mcause value; bit31 = interrupt
//  done         out  1   one-cycle pulse: request complete
//  rd_data      out  32  old CSR value (valid with done, CSR instr only)
//  illegal      out  1   valid with done: illegal CSR instruction
//  redirect     out  1   valid with done: fetch must jump to redirect_pc
//  redirect_pc  out  32  jump target
//  csr_raddr    out  12  CSR file read address (read data returns combinationally, same cycle)
//  csr_rdata    in   32  CSR file read data
//  csr_waddr    out  12  CSR file write address
//  csr_wdata    out  32  CSR file write data
//  csr_write    out  1   CSR file write enable (committed at clk edge)
// BEHAVIOUR
//  States: IDLE, EXEC, T_EPC, T_CAUSE, T_STAT, T_VEC, R_STAT, R_EPC, DONE. Reset -> IDLE.
//  Reset values: done/illegal/redirect/csr_write = 0; rd_data = 0; redirect_pc = RESET_VEC.
//   req_ready = 1 in IDLE only. csr_* address/data = 0 whenever the unit is in IDLE or DONE.
//  Request fields are latched at acceptance. Port inputs are ignored in all states except IDLE.
//  Accept at edge k:
//   - kind 00 -> EXEC in cycle k+1, DONE in cycle k+2.
//   - kind 01 -> T_EPC, T_CAUSE, T_STAT, T_VEC in cycles k+1..k+4, DONE in cycle k+5.
//   - kind 10 -> R_STAT in cycle k+1, R_EPC in cycle k+2, DONE in cycle k+3.
//   - kind 11 -> DONE in cycle k+1 with illegal=1 and no CSR write.
//   - DONE -> IDLE unconditionally. done, rd_data, illegal, redirect, redirect_pc are registered and valid in DONE.
//  Supported CSRs: MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MSTATUSH 0x310, MSCRATCH 0x340, MEPC 0x341, MCAUSE 0x342, MIP 0x344.
//  EXEC: raddr = csr_addr and rd_data <= csr_rdata. Write data by op:
//   - op 001/101 (RW/RWI): wdata = operand.
//   - op 010/110 (RS/RSI): wdata = rdata | operand.
//   - op 011/111 (RC/RCI): wdata = rdata & ~operand.
//   - csr_write = 1 except for RS/RC forms with src_zero = 1; for those the read still occurs and rd_data is returned.
//  Illegal CSR instruction: op 000 or 100, or unsupported csr_addr.
//   - csr_write = 0, rd_data = 0, illegal = 1 in DONE.
//  T_EPC: write MEPC = {trap_pc[31:2], 2'b00}.
//  T_CAUSE: write MCAUSE = trap_cause.
//  T_STAT: read MSTATUS and write it back with MPIE(7) <= MIE(3), MIE <= 0, MPP(12:11) <= 2'b11; other bits unchanged.
//  T_VEC: read MTVEC; base = {mtvec[31:2], 2'b00}.
//   - If mtvec[1:0] == 01 and trap_cause[31] = 1: target = base + {trap_cause[29:0], 2'b00}, mod 2^32.
//   - Otherwise target = base.
//   - In DONE: redirect = 1, redirect_pc = target.
//  R_STAT: read MSTATUS and write it back with MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.
//  R_EPC: read MEPC. In DONE: redirect = 1, redirect_pc = {mepc[31:2], 2'b00}.
//  Every sequence performs at most one CSR write per cycle, and writes occur in the order listed above.
//  rst asserted mid-sequence: state -> IDLE and csr_write -> 0 immediately (asynchronously). Writes already committed are not undone.
//  redirect_pc holds its last value when redirect = 0. Throughput: at most one CSR instruction every 3 cycles.
// TESTING
//  1. CSRRW 0x340, operand 0xDEADBEEF, MSCRATCH=0x12 -> single write 0xDEADBEEF at k+1; DONE at k+2 with rd_data=0x12, illegal=0.
//  2. CSRRS 0x304, src_zero=1, MIE=0x888 -> csr_write stays 0 throughout; rd_data=0x888.
//     CSRRC 0x300, operand 0x8, MSTATUS=0x1888 -> write 0x1880.
//  3. Trap, pc=0x1006, cause=0x8000_0007, MTVEC=0x101, MSTATUS=0x8 ->
//     writes MEPC=0x1004, MCAUSE=0x8000_0007, MSTATUS=0x1880 in consecutive cycles;
//     done at k+5 with redirect=1, redirect_pc=0x11C.
//  4. MRET, MSTATUS=0x1880, MEPC=0x2000 -> writes MSTATUS=0x1888; done at k+3 with redirect=1, redirect_pc=0x2000.
//  5. CSRRW 0x7C0 or funct3=000 -> no write; done with illegal=1, rd_data=0. req_kind=11 -> done at k+1 with illegal=1.
//  6. rst pulsed during T_CAUSE -> csr_write=0 that same cycle, unit in IDLE, req_ready=1;
//     MEPC holds the written value and MCAUSE is unchanged.
//     req_valid held high throughout -> exactly one acceptance per sequence.

Source files
------------

// File: rtl/csr_access_unit.sv
// csr_access_unit
// Initiator side of the CSR register-file port. Runs Zicsr read-modify-write
// accesses, trap entry and MRET as short sequences over one combinational
// read port and one clock-committed write port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready for a request; CSR port quiet
// S_EXEC    | CSR instruction: read old value, optionally write new value
// S_T_EPC   | trap entry: write MEPC with the word-aligned trapping PC
// S_T_CAUSE | trap entry: write MCAUSE
// S_T_STAT  | trap entry: stack MIE into MPIE, clear MIE, force MPP=M
// S_T_VEC   | trap entry: read MTVEC and form the handler address
// S_R_STAT  | MRET: restore MIE from MPIE, set MPIE, force MPP=M
// S_R_EPC   | MRET: read MEPC as the return address
// S_DONE    | one-cycle response; CSR port quiet
module csr_access_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] operand,
  input  logic        src_zero,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        illegal,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        csr_write
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSTATUSH = 12'h310;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;

  localparam logic [1:0] K_CSR  = 2'b00;
  localparam logic [1:0] K_TRAP = 2'b01;
  localparam logic [1:0] K_MRET = 2'b10;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [3:0] {
    S_IDLE,
    S_EXEC,
    S_T_EPC,
    S_T_CAUSE,
    S_T_STAT,
    S_T_VEC,
    S_R_STAT,
    S_R_EPC,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] operand_q;
  logic        src_zero_q;
  logic [31:0] trap_pc_q;
  logic [31:0] trap_cause_q;

  logic        done_nxt;
  logic [31:0] rd_data_nxt;
  logic        illegal_nxt;
  logic        redirect_nxt;
  logic [31:0] redirect_pc_nxt;

  logic        op_rw, op_set, op_clr;
  logic        instr_illegal;
  logic [31:0] trap_status;
  logic [31:0] mret_status;
  logic [31:0] vec_base;
  logic [31:0] vec_target;

  function automatic logic addr_supported(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSTATUSH,
      A_MSCRATCH, A_MEPC, A_MCAUSE, A_MIP: addr_supported = 1'b1;
      default:                             addr_supported = 1'b0;
    endcase
  endfunction

  // Decode the latched instruction; I forms behave like their register forms
  // because the operand already carries the zero-extended zimm.
  always_comb begin
    op_rw         = (op_q == 3'b001) || (op_q == 3'b101);
    op_set        = (op_q == 3'b010) || (op_q == 3'b110);
    op_clr        = (op_q == 3'b011) || (op_q == 3'b111);
    instr_illegal = (op_q == 3'b000) || (op_q == 3'b100) || !addr_supported(addr_q);
  end

  // mstatus rewrite for trap entry and MRET, and the trap handler address.
  always_comb begin
    trap_status        = csr_rdata;
    trap_status[7]     = csr_rdata[3];
    trap_status[3]     = 1'b0;
    trap_status[12:11] = 2'b11;

    mret_status        = csr_rdata;
    mret_status[3]     = csr_rdata[7];
    mret_status[7]     = 1'b1;
    mret_status[12:11] = 2'b11;

    vec_base = csr_rdata & ALIGN_MASK;
    if ((csr_rdata[1:0] == 2'b01) && trap_cause_q[31])
      vec_target = vec_base + {trap_cause_q[29:0], 2'b00};
    else
      vec_target = vec_base;
  end

  // Next state, CSR port drive and the values registered for the response.
  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    csr_raddr       = 12'h000;
    csr_waddr       = 12'h000;
    csr_wdata       = 32'h0000_0000;
    csr_write       = 1'b0;
    done_nxt        = 1'b0;
    rd_data_nxt     = rd_data;
    illegal_nxt     = 1'b0;
    redirect_nxt    = 1'b0;
    redirect_pc_nxt = redirect_pc;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_kind)
            K_CSR:   state_nxt = S_EXEC;
            K_TRAP:  state_nxt = S_T_EPC;
            K_MRET:  state_nxt = S_R_STAT;
            default: begin
              state_nxt   = S_DONE;
              done_nxt    = 1'b1;
              illegal_nxt = 1'b1;
              rd_data_nxt = 32'h0000_0000;
            end
          endcase
        end
      end

      S_EXEC: begin
        csr_raddr = addr_q;
        csr_waddr = addr_q;
        state_nxt = S_DONE;
        done_nxt  = 1'b1;
        if (instr_illegal) begin
          illegal_nxt = 1'b1;
          rd_data_nxt = 32'h0000_0000;
        end else begin
          rd_data_nxt = csr_rdata;
          // Set/clear with a zero source is a pure read.
          csr_write   = op_rw || !src_zero_q;
          if (op_set)
            csr_wdata = csr_rdata | operand_q;
          else if (op_clr)
            csr_wdata = csr_rdata & ~operand_q;
          else
            csr_wdata = operand_q;
        end
      end

      S_T_EPC: begin
        csr_waddr = A_MEPC;
        csr_wdata = trap_pc_q & ALIGN_MASK;
        csr_write = 1'b1;
        state_nxt = S_T_CAUSE;
      end

      S_T_CAUSE: begin
        csr_waddr = A_MCAUSE;
        csr_wdata = trap_cause_q;
        csr_write = 1'b1;
        state_nxt = S_T_STAT;
      end

      S_T_STAT: begin
        csr_raddr = A_MSTATUS;
        csr_waddr = A_MSTATUS;
        csr_wdata = trap_status;
        csr_write = 1'b1;
        state_nxt = S_T_VEC;
      end

      S_T_VEC: begin
        csr_raddr       = A_MTVEC;
        state_nxt       = S_DONE;
        done_nxt        = 1'b1;
        rd_data_nxt     = 32'h0000_0000;
        redirect_nxt    = 1'b1;
        redirect_pc_nxt = vec_target;
      end

      S_R_STAT: begin
        csr_raddr = A_MSTATUS;
        csr_waddr = A_MSTATUS;
        csr_wdata = mret_status;
        csr_write = 1'b1;
        state_nxt = S_R_EPC;
      end

      S_R_EPC: begin
        csr_raddr       = A_MEPC;
        state_nxt       = S_DONE;
        done_nxt        = 1'b1;
        rd_data_nxt     = 32'h0000_0000;
        redirect_nxt    = 1'b1;
        redirect_pc_nxt = csr_rdata & ALIGN_MASK;
      end

      S_DONE: state_nxt = S_IDLE;

      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      rd_data     <= 32'h0000_0000;
      illegal     <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= RESET_VEC;
    end else begin
      state       <= state_nxt;
      done        <= done_nxt;
      rd_data     <= rd_data_nxt;
      illegal     <= illegal_nxt;
      redirect    <= redirect_nxt;
      redirect_pc <= redirect_pc_nxt;
    end
  end

  // Capture the request at acceptance so later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= 3'b000;
      addr_q       <= 12'h000;
      operand_q    <= 32'h0000_0000;
      src_zero_q   <= 1'b0;
      trap_pc_q    <= 32'h0000_0000;
      trap_cause_q <= 32'h0000_0000;
    end else if ((state == S_IDLE) && req_valid) begin
      op_q         <= csr_op;
      addr_q       <= csr_addr;
      operand_q    <= operand;
      src_zero_q   <= src_zero;
      trap_pc_q    <= trap_pc;
      trap_cause_q <= trap_cause;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit
// Drives csr_access_unit against a behavioural CSR file and a request-level
// reference model (expected write list, latency and response per request).
module tb_csr_access_unit;

  localparam logic [31:0] RV = 32'h8000_0040;

  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_kind;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] operand;
  logic        src_zero;
  logic [31:0] trap_pc, trap_cause;
  logic        done;
  logic [31:0] rd_data;
  logic        illegal, redirect;
  logic [31:0] redirect_pc;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_write;

  csr_access_unit #(.RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .csr_op(csr_op), .csr_addr(csr_addr), .operand(operand), .src_zero(src_zero),
    .trap_pc(trap_pc), .trap_cause(trap_cause),
    .done(done), .rd_data(rd_data), .illegal(illegal),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_write(csr_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CSR file: combinational read, write at the clock edge.
  logic [31:0] mem [0:4095];
  logic        tb_we;
  logic [11:0] tb_addr;
  logic [31:0] tb_data;
  assign csr_rdata = mem[csr_raddr];
  always @(posedge clk) begin
    if (csr_write) mem[csr_waddr] <= csr_wdata;
    else if (tb_we) mem[tb_addr] <= tb_data;
  end

  logic [11:0] sup [8] = '{12'h300, 12'h304, 12'h305, 12'h310,
                           12'h340, 12'h341, 12'h342, 12'h344};

  // Reference model state.
  logic [31:0] ref_csr [0:4095];
  logic [31:0] last_pc;
  logic [47:0] exp_w[$];
  logic [47:0] obs_w[$];
  int          e_lat;
  logic [31:0] e_rd, e_pc;
  logic        e_ill, e_redir;
  logic [31:0] o_rd, o_pc;
  logic        o_ill, o_redir;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
    ref_csr[a] = d;
  endtask

  // Request-level model: what the CSR file must see and what comes back.
  task automatic model_req(input logic [1:0] kind, input logic [2:0] op,
                           input logic [11:0] addr, input logic [31:0] opnd,
                           input logic sz, input logic [31:0] tpc,
                           input logic [31:0] tcause);
    logic        legal;
    logic [31:0] old, nv, st, mtvec, base;
    int          f;
    exp_w.delete();
    e_rd = 32'h0; e_ill = 1'b0; e_redir = 1'b0;
    case (kind)
      2'b00: begin
        e_lat = 2;
        f = int'(op) % 4;
        legal = 1'b0;
        for (int i = 0; i < 8; i++) if (sup[i] == addr) legal = 1'b1;
        if (f == 0) legal = 1'b0;
        if (!legal) e_ill = 1'b1;
        else begin
          old = ref_csr[addr];
          e_rd = old;
          nv = (f == 1) ? opnd : (f == 2) ? (old | opnd) : (old & ~opnd);
          if (f == 1 || !sz) begin
            exp_w.push_back({4'd1, addr, nv});
            ref_csr[addr] = nv;
          end
        end
      end
      2'b01: begin
        e_lat = 5;
        exp_w.push_back({4'd1, 12'h341, tpc - (tpc % 4)});
        exp_w.push_back({4'd2, 12'h342, tcause});
        st = ref_csr[12'h300];
        nv = (st & ~32'h0000_1888) | (st[3] ? 32'h80 : 32'h0) | 32'h1800;
        exp_w.push_back({4'd3, 12'h300, nv});
        ref_csr[12'h341] = tpc - (tpc % 4);
        ref_csr[12'h342] = tcause;
        ref_csr[12'h300] = nv;
        mtvec = ref_csr[12'h305];
        base  = mtvec - (mtvec % 4);
        if ((mtvec % 4) == 1 && tcause[31]) last_pc = base + (tcause % 32'h4000_0000) * 4;
        else last_pc = base;
        e_redir = 1'b1;
      end
      2'b10: begin
        e_lat = 3;
        st = ref_csr[12'h300];
        nv = (st & ~32'h0000_1888) | (st[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
        exp_w.push_back({4'd1, 12'h300, nv});
        ref_csr[12'h300] = nv;
        last_pc = ref_csr[12'h341] - (ref_csr[12'h341] % 4);
        e_redir = 1'b1;
      end
      default: begin
        e_lat = 1;
        e_ill = 1'b1;
      end
    endcase
    e_pc = last_pc;
  endtask

  // Issue one request, watch the CSR port until done, compare with the model.
  task automatic do_request(input logic [1:0] kind, input logic [2:0] op,
                            input logic [11:0] addr, input logic [31:0] opnd,
                            input logic sz, input logic [31:0] tpc,
                            input logic [31:0] tcause);
    int  lat;
    int  wait_n;
    model_req(kind, op, addr, opnd, sz, tpc, tcause);
    obs_w.delete();
    @(negedge clk);
    wait_n = 0;
    while (!req_ready && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    n_checks++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_kind = kind; csr_op = op; csr_addr = addr;
    operand = opnd; src_zero = sz; trap_pc = tpc; trap_cause = tcause;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_kind = 2'($urandom); csr_op = 3'($urandom); csr_addr = 12'($urandom);
    operand = $urandom; src_zero = 1'($urandom); trap_pc = $urandom; trap_cause = $urandom;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (csr_write) obs_w.push_back({4'(n), csr_waddr, csr_wdata});
      if (done) begin
        lat = n;
        o_rd = rd_data; o_ill = illegal; o_redir = redirect; o_pc = redirect_pc;
        n_checks++;
        if (csr_write !== 1'b0 || csr_waddr !== 12'h0 || csr_wdata !== 32'h0 || csr_raddr !== 12'h0) begin
          n_fail++;
          $display("FAIL port_quiet_in_done: we=%b wa=%h wd=%h ra=%h required all 0",
                   csr_write, csr_waddr, csr_wdata, csr_raddr);
        end
        break;
      end
    end
    n_checks++;
    if (lat !== e_lat) begin
      n_fail++;
      $display("FAIL latency kind=%0d: got %0d cycles required %0d", kind, lat, e_lat);
      return;
    end
    n_checks++;
    if (obs_w.size() !== exp_w.size()) begin
      n_fail++;
      $display("FAIL write_count kind=%0d: got %0d required %0d", kind, obs_w.size(), exp_w.size());
    end
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++) begin
      n_checks++;
      if (obs_w[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL write[%0d] kind=%0d: got cyc/addr/data %h required %h", i, kind, obs_w[i], exp_w[i]);
      end
    end
    if (kind == 2'b00) begin
      n_checks++;
      if (o_rd !== e_rd) begin
        n_fail++;
        $display("FAIL rd_data addr=%h op=%0d: got %h required %h", addr, op, o_rd, e_rd);
      end
    end
    n_checks++;
    if (o_ill !== e_ill) begin
      n_fail++;
      $display("FAIL illegal kind=%0d op=%0d addr=%h: got %b required %b", kind, op, addr, o_ill, e_ill);
    end
    n_checks++;
    if (o_redir !== e_redir) begin
      n_fail++;
      $display("FAIL redirect kind=%0d: got %b required %b", kind, o_redir, e_redir);
    end
    n_checks++;
    if (o_pc !== e_pc) begin
      n_fail++;
      $display("FAIL redirect_pc kind=%0d: got %h required %h", kind, o_pc, e_pc);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b ready=%b required 0/1", done, req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[sup[i]] !== ref_csr[sup[i]]) begin
        n_fail++;
        $display("FAIL csr_file[%h]: got %h required %h", sup[i], mem[sup[i]], ref_csr[sup[i]]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_kind = 2'b00; csr_op = 3'b000; csr_addr = 12'h0;
    operand = 32'h0; src_zero = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
    tb_we = 1'b0; tb_addr = 12'h0; tb_data = 32'h0;
    last_pc = RV;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || done !== 1'b0 || illegal !== 1'b0 || redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b done=%b ill=%b redir=%b required 1/0/0/0",
               req_ready, done, illegal, redirect);
    end
    n_checks++;
    if (rd_data !== 32'h0 || redirect_pc !== RV) begin
      n_fail++;
      $display("FAIL reset_data: rd=%h pc=%h required 0/%h", rd_data, redirect_pc, RV);
    end
    n_checks++;
    if (csr_write !== 1'b0 || csr_waddr !== 12'h0 || csr_wdata !== 32'h0 || csr_raddr !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_port: we=%b wa=%h wd=%h ra=%h required all 0",
               csr_write, csr_waddr, csr_wdata, csr_raddr);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) set_csr(sup[i], 32'h0);
  endtask

  task automatic test_csr_rw();
    set_csr(12'h340, 32'h12);
    do_request(2'b00, 3'b001, 12'h340, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (o_rd !== 32'h12 || mem[12'h340] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL csrrw_direct: rd=%h mscratch=%h required 12/deadbeef", o_rd, mem[12'h340]);
    end
  endtask

  task automatic test_set_clear();
    set_csr(12'h304, 32'h888);
    do_request(2'b00, 3'b010, 12'h304, 32'h0, 1'b1, 32'h0, 32'h0);
    set_csr(12'h300, 32'h1888);
    do_request(2'b00, 3'b011, 12'h300, 32'h8, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (mem[12'h300] !== 32'h1880) begin
      n_fail++;
      $display("FAIL csrrc_direct: mstatus=%h required 1880", mem[12'h300]);
    end
    do_request(2'b00, 3'b111, 12'h304, 32'h0, 1'b1, 32'h0, 32'h0);
  endtask

  task automatic test_trap();
    set_csr(12'h305, 32'h101);
    set_csr(12'h300, 32'h8);
    do_request(2'b01, 3'b000, 12'h0, 32'h0, 1'b0, 32'h1006, 32'h8000_0007);
    n_checks++;
    if (o_pc !== 32'h11C || mem[12'h341] !== 32'h1004 || mem[12'h300] !== 32'h1880) begin
      n_fail++;
      $display("FAIL trap_direct: pc=%h mepc=%h mstatus=%h required 11c/1004/1880",
               o_pc, mem[12'h341], mem[12'h300]);
    end
    do_request(2'b01, 3'b000, 12'h0, 32'h0, 1'b0, 32'h2223, 32'h0000_0003);
  endtask

  task automatic test_mret();
    set_csr(12'h300, 32'h1880);
    set_csr(12'h341, 32'h2000);
    do_request(2'b10, 3'b000, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (o_pc !== 32'h2000 || mem[12'h300] !== 32'h1888) begin
      n_fail++;
      $display("FAIL mret_direct: pc=%h mstatus=%h required 2000/1888", o_pc, mem[12'h300]);
    end
  endtask

  task automatic test_illegal();
    do_request(2'b00, 3'b001, 12'h7C0, 32'h1234, 1'b0, 32'h0, 32'h0);
    do_request(2'b00, 3'b000, 12'h340, 32'h1234, 1'b0, 32'h0, 32'h0);
    do_request(2'b00, 3'b100, 12'h341, 32'h1234, 1'b0, 32'h0, 32'h0);
    do_request(2'b11, 3'b001, 12'h340, 32'h1234, 1'b0, 32'h0, 32'h0);
    n_checks++;
    if (o_ill !== 1'b1) begin
      n_fail++;
      $display("FAIL reserved_kind: illegal=%b required 1", o_ill);
    end
  endtask

  task automatic test_reset_mid();
    set_csr(12'h341, 32'h55);
    set_csr(12'h342, 32'h66);
    @(negedge clk);
    req_valid = 1'b1; req_kind = 2'b01; trap_pc = 32'h2008; trap_cause = 32'h11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (csr_write !== 1'b1 || csr_waddr !== 12'h342) begin
      n_fail++;
      $display("FAIL mid_pre: we=%b wa=%h required 1/342", csr_write, csr_waddr);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (csr_write !== 1'b0 || req_ready !== 1'b1 || redirect_pc !== RV) begin
      n_fail++;
      $display("FAIL mid_reset: we=%b ready=%b pc=%h required 0/1/%h", csr_write, req_ready, redirect_pc, RV);
    end
    @(negedge clk);
    rst = 1'b0;
    ref_csr[12'h341] = 32'h2008;
    last_pc = RV;
    n_checks++;
    if (mem[12'h341] !== 32'h2008 || mem[12'h342] !== 32'h66) begin
      n_fail++;
      $display("FAIL mid_csrs: mepc=%h mcause=%h required 2008/66", mem[12'h341], mem[12'h342]);
    end
  endtask

  task automatic test_back_to_back();
    int acc, dn;
    logic rdy;
    acc = 0; dn = 0;
    @(negedge clk);
    req_valid = 1'b1; req_kind = 2'b00; csr_op = 3'b001; csr_addr = 12'h340;
    operand = 32'hA5A5_0001; src_zero = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      rdy = req_ready;
      if (done) dn++;
      @(posedge clk);
      if (rdy) acc++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    ref_csr[12'h340] = 32'hA5A5_0001;
    n_checks++;
    if (acc !== 3 || dn !== 3) begin
      n_fail++;
      $display("FAIL back_to_back: accepts=%0d dones=%0d required 3/3", acc, dn);
    end
    n_checks++;
    if (mem[12'h340] !== 32'hA5A5_0001 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back_end: mscratch=%h ready=%b required a5a50001/1", mem[12'h340], req_ready);
    end
  endtask

  task automatic test_random();
    logic [1:0]  k;
    logic [11:0] a;
    logic [31:0] d, c;
    logic        z;
    for (int i = 0; i < 200; i++) begin
      k = ($urandom % 10 < 6) ? 2'b00 : 2'($urandom);
      a = ($urandom % 6 == 0) ? 12'($urandom) : sup[$urandom % 8];
      z = ($urandom % 4 == 0);
      d = z ? 32'h0 : $urandom;
      c = $urandom;
      if ($urandom % 2 == 0) c[30:8] = '0;
      do_request(k, 3'($urandom), a, d, z, $urandom, c);
    end
  endtask

  initial begin
    test_reset();
    test_csr_rw();
    test_set_clear();
    test_trap();
    test_mret();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
